// File: rtl/aes_mux_pkg.sv
// Shared constants for the AES datapath muxes.
package aes_mux_pkg;

  // One AES state, in bits.
  localparam int AES_STATE_W    = 128;
  // Default number of input channels on the AES muxes.
  localparam int MUXN_DEFAULT_N = 2;

endpackage

// File: rtl/pipe_mux_n_rr_arbiter.sv
// Round-robin arbiter for pipe_mux_n: grants the first requester at or after
// the pointer, wrapping N-1 -> 0. The pointer moves past the grant only when
// the caller reports that the grant was actually consumed (advance).
module rr_arbiter #(
  parameter int N = 2,
  localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  logic [SEL_W-1:0] ptr;

  // Scan from the farthest candidate back to the pointer so the nearest requester wins.
  always_comb begin
    int j;
    grant       = ptr;
    grant_valid = 1'b0;
    j           = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant       = SEL_W'(j);
        grant_valid = 1'b1;
      end
    end
  end

  // Pointer moves to the channel after the consumed grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N-channel mux feeding a one-entry output register with valid/ready on both
// sides. Channel choice comes from sel by default; defining MUXN_RR_ARB_EN
// replaces sel with a round-robin arbiter over in_valid (sel ignored, err_sel 0).
module pipe_mux_n
  import aes_mux_pkg::*;
#(
  parameter int WIDTH = AES_STATE_W,
  parameter int N     = MUXN_DEFAULT_N,
  localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel,
  output logic               err_sel
);

  logic             can_load;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             xfer;
  logic             err_d;
  logic [WIDTH-1:0] grant_data;

  assign can_load = !out_valid || out_ready;

`ifdef MUXN_RR_ARB_EN
  logic unused_sel;
  assign unused_sel = ^sel;
  assign err_d      = 1'b0;

  rr_arbiter #(.N(N)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (xfer),
    .grant       (grant),
    .grant_valid (grant_ok)
  );
`else
  logic sel_ok;

  // With a power-of-two N every sel code names a real channel.
  if ((1 << SEL_W) == N) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_partial
    assign sel_ok = (int'(sel) < N);
  end

  assign grant = sel;
  assign grant_ok = sel_ok;
  assign err_d = !sel_ok;
`endif

  assign grant_data = in_data[grant*WIDTH +: WIDTH];
  assign xfer       = can_load && grant_ok && in_valid[grant];

  // Only the granted channel sees ready, and only when the output slot can take a word.
  always_comb begin
    in_ready = '0;
    if (can_load && grant_ok) in_ready[grant] = 1'b1;
  end

  // Output register: load on transfer, drain on accept, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      err_sel   <= 1'b0;
    end else begin
      err_sel <= err_d;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n. Main instance is N=2 select mode by default, N=4 when
// MUXN_RR_ARB_EN is defined; a second N=3 instance covers the illegal-select pulse.
`timescale 1ns/1ps
module tb_pipe_mux_n;

  localparam int W = 128;
`ifdef MUXN_RR_ARB_EN
  localparam int MN = 4;
`else
  localparam int MN = 2;
`endif
  localparam int MSW = (MN > 2) ? $clog2(MN) : 1;

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } item_t;

  logic            clk;
  logic            rst_n;
  logic [MN*W-1:0] m_in_data;
  logic [MN-1:0]   m_in_valid, m_in_ready;
  logic [MSW-1:0]  m_sel, m_out_sel;
  logic [W-1:0]    m_out_data;
  logic            m_out_valid, m_out_ready, m_err;

  logic [3*W-1:0]  e_in_data;
  logic [2:0]      e_in_valid, e_in_ready;
  logic [1:0]      e_sel, e_out_sel;
  logic [W-1:0]    e_out_data;
  logic            e_out_valid, e_out_ready, e_err;

  item_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  bit    m_occ;
  int    rr_p;

  pipe_mux_n #(.WIDTH(W), .N(MN)) u_main (
    .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .sel(m_sel), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_sel(m_out_sel), .err_sel(m_err)
  );

  pipe_mux_n #(.WIDTH(W), .N(3)) u_err (
    .clk(clk), .rst_n(rst_n), .in_data(e_in_data), .in_valid(e_in_valid),
    .in_ready(e_in_ready), .sel(e_sel), .out_data(e_out_data), .out_valid(e_out_valid),
    .out_ready(e_out_ready), .out_sel(e_out_sel), .err_sel(e_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [MN*W-1:0] rnd_bus();
    logic [MN*W-1:0] r;
    for (int i = 0; i < MN; i++) r[i*W +: W] = rnd_word();
    return r;
  endfunction

  // One cycle of main-instance stimulus, with the reference model deciding the
  // expected ready pattern and whether a word enters the output slot.
  task automatic drive(input logic [MN-1:0] v, input int s, input logic [MN*W-1:0] d, input logic ordy);
    bit            can, ok, xfer;
    int            g;
    logic [MN-1:0] er;
    item_t         it;
    @(negedge clk);
    m_in_valid  = v;
    m_sel       = s[MSW-1:0];
    m_in_data   = d;
    m_out_ready = ordy;
    #1;
    can = !m_occ || ordy;
    ok  = 1'b0;
    g   = 0;
`ifdef MUXN_RR_ARB_EN
    for (int k = 0; k < MN; k++) begin
      if (!ok && v[(rr_p + k) % MN]) begin
        ok = 1'b1;
        g  = (rr_p + k) % MN;
      end
    end
`else
    g  = s;
    ok = (s < MN);
`endif
    er = '0;
    if (ok && can) er[g] = 1'b1;
    chk("in_ready", W'(m_in_ready), W'(er));
    chk("out_valid", W'(m_out_valid), W'(m_occ));
    xfer = ok && can && v[g];
    if (xfer) begin
      it.d = d[g*W +: W];
      it.s = g;
      sbq.push_back(it);
`ifdef MUXN_RR_ARB_EN
      rr_p = (g + 1) % MN;
`endif
    end
    m_occ = xfer ? 1'b1 : (ordy ? 1'b0 : m_occ);
  endtask

  // Monitor: whatever the DUT presents must match the oldest expected word;
  // the word leaves the scoreboard when downstream accepts it.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && m_out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: out_valid=1 with data %0h but nothing expected", m_out_data);
      end else begin
        chk("out_data", m_out_data, sbq[0].d);
        chk("out_sel", W'(m_out_sel), W'(sbq[0].s));
        if (m_out_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    logic [MN*W-1:0] bus;
    logic [W-1:0]    words[4];
    logic [W-1:0]    held;
    logic [W-1:0]    a5;

    rst_n = 1'b0;
    m_in_data = '0; m_in_valid = '0; m_sel = '0; m_out_ready = 1'b0;
    e_in_data = '0; e_in_valid = '0; e_sel = '0; e_out_ready = 1'b0;
    m_occ = 1'b0; rr_p = 0;
    a5 = {16{8'hA5}};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(m_out_valid), '0);
    chk("rst_out_data", m_out_data, '0);
    chk("rst_out_sel", W'(m_out_sel), '0);
    chk("rst_err_sel", W'(e_err), '0);
    #2 rst_n = 1'b1;

`ifdef MUXN_RR_ARB_EN
    // All four requesting: grants rotate 0,1,2,3,0,1,2,3; then only ch2.
    for (int k = 0; k < 9; k++) begin
      drive((k < 8) ? 4'b1111 : 4'b0100, 0, rnd_bus(), 1'b1);
      if (k >= 1) chk("rr_order", W'(m_out_sel), W'((k - 1) % 4));
    end
    drive(4'b0000, 0, rnd_bus(), 1'b1);
    chk("rr_single", W'(m_out_sel), W'(2));
    drive(4'b0000, 0, rnd_bus(), 1'b1);
`else
    // Single transfer from ch1, visible one cycle later.
    bus = rnd_bus();
    bus[W +: W] = a5;
    drive(2'b10, 1, bus, 1'b1);
    drive(2'b00, 1, rnd_bus(), 1'b1);
    chk("lat_valid", W'(m_out_valid), W'(1));
    chk("lat_sel", W'(m_out_sel), W'(1));
    chk("lat_data", m_out_data, a5);

    // Back-to-back stream on ch0 with no bubbles.
    for (int k = 0; k < 5; k++) begin
      bus = rnd_bus();
      if (k < 4) words[k] = bus[0 +: W];
      drive((k < 4) ? 2'b01 : 2'b00, 0, bus, 1'b1);
      if (k >= 1) begin
        chk("stream_valid", W'(m_out_valid), W'(1));
        chk("stream_data", m_out_data, words[k - 1]);
      end
    end

    // Stall with toggling sel/data, then simultaneous drain and load.
    bus = rnd_bus();
    held = bus[0 +: W];
    drive(2'b01, 0, bus, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, k % 2, rnd_bus(), 1'b0);
      chk("stall_ready", W'(m_in_ready), '0);
      chk("stall_data", m_out_data, held);
      chk("stall_sel", W'(m_out_sel), '0);
    end
    bus = rnd_bus();
    drive(2'b10, 1, bus, 1'b1);
    drive(2'b00, 0, rnd_bus(), 1'b1);
    chk("swap_valid", W'(m_out_valid), W'(1));
    chk("swap_data", m_out_data, bus[W +: W]);

    // Reset dropped between edges during a stall.
    drive(2'b01, 0, rnd_bus(), 1'b0);
    drive(2'b01, 0, rnd_bus(), 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(m_out_valid), '0);
    chk("arst_data", m_out_data, '0);
    chk("arst_sel", W'(m_out_sel), '0);
    sbq.delete();
    m_occ = 1'b0;
    rr_p = 0;
    @(posedge clk);
    #1 chk("arst_hold", W'(m_out_valid), '0);
    #3 rst_n = 1'b1;
    bus = rnd_bus();
    drive(2'b10, 1, bus, 1'b1);
    drive(2'b00, 0, rnd_bus(), 1'b1);
    chk("post_rst_data", m_out_data, bus[W +: W]);
    chk("post_rst_sel", W'(m_out_sel), W'(1));
`endif

    // Illegal select on the N=3 instance.
    e_in_data = {rnd_word(), rnd_word(), rnd_word()};
`ifdef MUXN_RR_ARB_EN
    e_sel = 2'd3; e_in_valid = 3'b000; e_out_ready = 1'b1;
    drive('0, 0, rnd_bus(), 1'b1);
    chk("arb_err_tied", W'(e_err), '0);
    drive('0, 0, rnd_bus(), 1'b1);
    chk("arb_err_tied", W'(e_err), '0);
`else
    e_sel = 2'd3; e_in_valid = 3'b111; e_out_ready = 1'b1;
    #1 chk("err_ready", W'(e_in_ready), '0);
    drive('0, 0, rnd_bus(), 1'b1);
    chk("err_pulse", W'(e_err), W'(1));
    chk("err_no_xfer", W'(e_out_valid), '0);
    e_sel = 2'd1; e_out_ready = 1'b0;
    #1 chk("err_ready_ok", W'(e_in_ready), W'(3'b010));
    drive('0, 0, rnd_bus(), 1'b1);
    chk("err_clear", W'(e_err), '0);
    chk("err_load_valid", W'(e_out_valid), W'(1));
    chk("err_load_sel", W'(e_out_sel), W'(1));
    chk("err_load_data", e_out_data, e_in_data[W +: W]);
    e_sel = 2'd3;
    drive('0, 0, rnd_bus(), 1'b1);
    chk("err_pulse2", W'(e_err), W'(1));
    chk("err_keep_valid", W'(e_out_valid), W'(1));
    chk("err_keep_data", e_out_data, e_in_data[W +: W]);
    e_sel = 2'd2;
    drive('0, 0, rnd_bus(), 1'b1);
    chk("err_one_cycle", W'(e_err), '0);
    chk("err_keep_sel", W'(e_out_sel), W'(1));
`endif

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      drive(MN'($urandom()), int'($urandom_range(0, MN - 1)), rnd_bus(), 1'($urandom_range(0, 3) != 0));
    end
    drive('0, 0, rnd_bus(), 1'b1);
    drive('0, 0, rnd_bus(), 1'b1);
    chk("drained", W'(sbq.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, meaning the per-channel data width in bits (one AES state).
REQ-002 The block SHALL have parameter N, default 2, meaning the number of input channels (legal range 2..16).
REQ-003 The block SHALL have localparam SEL_W = max(1, clog2(N)), meaning the select width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock (all logic on its rising edge).
REQ-005 The block SHALL have port rst_n, input, 1, meaning the reset: asynchronous, active-low.
REQ-006 The block SHALL have port in_data, input, N*WIDTH, meaning packed channel data, with channel i in bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, N, meaning the per-channel valid.
REQ-008 The block SHALL have port in_ready, output, N, meaning the per-channel ready (combinational).
REQ-009 The block SHALL have port sel, input, SEL_W, meaning the channel select; it is ignored when MUXN_RR_ARB_EN is defined.
REQ-010 The block SHALL have port out_data, output, WIDTH, meaning the registered selected data.
REQ-011 The block SHALL have port out_valid, output, 1, meaning the output register holds valid data.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the downstream accepts data.
REQ-013 The block SHALL have port out_sel, output, SEL_W, meaning the index of the channel captured in out_data.
REQ-014 The block SHALL have port err_sel, output, 1, meaning a registered one-cycle pulse raised when sel >= N while in non-arbiter mode.

Function
REQ-015 The block SHALL provide a one-entry output register; can_load = !out_valid || out_ready.
REQ-016 In non-arbiter mode, the block SHALL drive in_ready[i] = can_load && (sel == i) && (sel < N); all other bits SHALL be 0.
REQ-017 The block SHALL perform a transfer on a cycle where in_valid[g] && in_ready[g] for grant g; at the next edge it SHALL set out_data to channel g data, out_sel to g and out_valid to 1.
REQ-018 Input-to-output latency SHALL be exactly 1 cycle, with full throughput of 1 transfer per cycle when out_ready is held at 1.
REQ-019 If out_valid && out_ready occurs with no transfer, the block SHALL clear out_valid at the next edge; out_data and out_sel SHALL hold their values.
REQ-020 While out_valid && !out_ready, the block SHALL keep out_data, out_sel and out_valid stable, and all in_ready bits SHALL be 0.
REQ-021 A simultaneous drain and load in the same cycle SHALL replace the output with the new data, with out_valid remaining 1 and no bubble.
REQ-022 When sel >= N (non-power-of-two N), the block SHALL perform no transfer and SHALL pulse err_sel high for one cycle at the next edge; the output register SHALL be unaffected.
REQ-023 A change of sel while the output is stalled SHALL have no effect on the held output.

Reset
REQ-024 Asserting rst_n low SHALL immediately force out_valid=0, out_data=0, out_sel=0, err_sel=0 and the arbiter pointer=0, regardless of clk.
REQ-025 A reset asserted mid-stall SHALL discard the held word; after release, the first transfer SHALL occur no earlier than the first rising edge with rst_n high.
REQ-026 In-flight data SHALL NOT be retained across reset.

Configuration
REQ-027 The block SHALL support macro MUXN_RR_ARB_EN.
REQ-028 With MUXN_RR_ARB_EN undefined, grant SHALL equal sel as specified above.
REQ-029 With MUXN_RR_ARB_EN defined, sel and err_sel SHALL be unused (err_sel tied to 0), and grant SHALL be the first requesting channel at or after pointer p (wrapping N-1 -> 0).
REQ-030 With MUXN_RR_ARB_EN defined, in_ready[grant] = can_load and all other bits SHALL be 0.
REQ-031 With MUXN_RR_ARB_EN defined, p SHALL be set to (grant+1) mod N only on a transfer.
REQ-032 With MUXN_RR_ARB_EN defined, when there are no requests the block SHALL assert no in_ready bits and leave p unchanged.

Structure
REQ-033 Shared package aes_mux_pkg SHALL hold the AES_STATE_W=128 constant and the default N; SEL_W SHALL remain a local derivation.
REQ-034 Sub-module rr_arbiter (parameter N; inputs req[N], advance; output grant index plus grant_valid; internal pointer) SHALL be instantiated only under MUXN_RR_ARB_EN.

Verification
REQ-035 The bench SHALL check: N=2, WIDTH=128, sel=1, in_valid=2'b10, ch1=0xA5..A5, out_ready=1 -> out_data=0xA5..A5, out_sel=1, out_valid=1 one cycle later.
REQ-036 The bench SHALL check: stream 4 words on ch0 with out_ready=1 -> 4 consecutive out_valid cycles with no bubble and in-order data.
REQ-037 The bench SHALL check: out_ready=0 for 3 cycles with out_valid=1 while sel and in_data toggle -> output stable and in_ready=0; release -> next word loads in the same cycle the held word drains.
REQ-038 The bench SHALL check: N=3, sel=3 with in_valid=3'b111 -> no transfer, err_sel=1 for exactly one cycle, out_valid unchanged.
REQ-039 The bench SHALL check: rst_n dropped mid-clock during a stall -> out_valid=0 and out_data=0 immediately; after release, normal transfer on the next valid cycle.
REQ-040 The bench SHALL check: MUXN_RR_ARB_EN defined, N=4, in_valid=4'b1111 for 8 transfers with out_ready=1 -> out_sel sequence 0,1,2,3,0,1,2,3; then in_valid=4'b0100 -> out_sel=2.
